// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, the delayed sync payload, and the width helpers
// used to size counters and addresses.
package vga_pkg;

   localparam int unsigned DEF_H_ACTIVE    = 800;
   localparam int unsigned DEF_H_FRONT     = 40;
   localparam int unsigned DEF_H_SYNC      = 128;
   localparam int unsigned DEF_H_BACK      = 88;
   localparam int unsigned DEF_V_ACTIVE    = 600;
   localparam int unsigned DEF_V_FRONT     = 1;
   localparam int unsigned DEF_V_SYNC      = 4;
   localparam int unsigned DEF_V_BACK      = 23;
   localparam int unsigned DEF_HSYNC_POL   = 1;
   localparam int unsigned DEF_VSYNC_POL   = 1;
   localparam int unsigned DEF_GRID_COLS   = 3;
   localparam int unsigned DEF_GRID_ROWS   = 3;
   localparam int unsigned DEF_TILE_W      = 280;
   localparam int unsigned DEF_TILE_H      = 215;
   localparam int unsigned DEF_CODE_W      = 4;
   localparam int unsigned DEF_NUM_SPRITES = 9;
   localparam int unsigned DEF_MEM_LAT     = 1;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic de;
      logic fs;
   } sync_t;

   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 32'd2) ? 32'd1 : unsigned'($clog2(n));
   endfunction

   function automatic int unsigned rom_aw(input int unsigned sprites,
                                          input int unsigned tw,
                                          input int unsigned th);
      return cnt_w(sprites * tw * th);
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus the combinational sync and display-enable decode for
// the current counter position.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
   parameter int unsigned H_FRONT   = DEF_H_FRONT,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_BACK    = DEF_H_BACK,
   parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
   parameter int unsigned V_FRONT   = DEF_V_FRONT,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_BACK    = DEF_V_BACK,
   parameter int unsigned HSYNC_POL = DEF_HSYNC_POL,
   parameter int unsigned VSYNC_POL = DEF_VSYNC_POL,
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
   localparam int unsigned HW       = cnt_w(H_TOTAL),
   localparam int unsigned VW       = cnt_w(V_TOTAL)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   output logic [HW-1:0] h_o,
   output logic [VW-1:0] v_o,
   output logic          hsync_c_o,
   output logic          vsync_c_o,
   output logic          de_c_o
);

   localparam logic HS_ON = (HSYNC_POL != 32'd0);
   localparam logic VS_ON = (VSYNC_POL != 32'd0);

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;

   // H wraps every line; V advances on the H wrap and wraps every frame.
   always_comb begin
      h_d = h_q + HW'(1);
      v_d = v_q;
      if (32'(h_q) == H_TOTAL - 32'd1) begin
         h_d = '0;
         v_d = (32'(v_q) == V_TOTAL - 32'd1) ? '0 : v_q + VW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   assign h_o       = h_q;
   assign v_o       = v_q;
   assign hsync_c_o = ((32'(h_q) >= H_ACTIVE + H_FRONT) &&
                       (32'(h_q) <  H_ACTIVE + H_FRONT + H_SYNC)) ? HS_ON : ~HS_ON;
   assign vsync_c_o = ((32'(v_q) >= V_ACTIVE + V_FRONT) &&
                       (32'(v_q) <  V_ACTIVE + V_FRONT + V_SYNC)) ? VS_ON : ~VS_ON;
   assign de_c_o    = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);

endmodule

// File: rtl/vga_grid_controller.sv
// Tile-grid VGA controller: per-frame latched tile codes drive a sprite ROM
// lookup; syncs are delayed to stay aligned with the returned pixel.
module vga_grid_controller
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
   parameter int unsigned H_FRONT     = DEF_H_FRONT,
   parameter int unsigned H_SYNC      = DEF_H_SYNC,
   parameter int unsigned H_BACK      = DEF_H_BACK,
   parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
   parameter int unsigned V_FRONT     = DEF_V_FRONT,
   parameter int unsigned V_SYNC      = DEF_V_SYNC,
   parameter int unsigned V_BACK      = DEF_V_BACK,
   parameter int unsigned HSYNC_POL   = DEF_HSYNC_POL,
   parameter int unsigned VSYNC_POL   = DEF_VSYNC_POL,
   parameter int unsigned GRID_COLS   = DEF_GRID_COLS,
   parameter int unsigned GRID_ROWS   = DEF_GRID_ROWS,
   parameter int unsigned TILE_W      = DEF_TILE_W,
   parameter int unsigned TILE_H      = DEF_TILE_H,
   parameter int unsigned CODE_W      = DEF_CODE_W,
   parameter int unsigned NUM_SPRITES = DEF_NUM_SPRITES,
   parameter int unsigned MEM_LAT     = DEF_MEM_LAT,
   localparam int unsigned ROM_AW     = rom_aw(NUM_SPRITES, TILE_W, TILE_H)
) (
   input  logic                                 CLK,
   input  logic                                 RESET_N,
   input  logic [GRID_COLS*GRID_ROWS*CODE_W-1:0] CONTROL_ARRAY,
   output logic [ROM_AW-1:0]                    ROM_ADDR,
   input  logic                                 ROM_DATA,
   output logic                                 PIXEL_VALUE,
   output logic                                 PIXEL_VALID,
   output logic                                 HSYNC,
   output logic                                 VSYNC,
   output logic                                 FRAME_START
);

   localparam int unsigned H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HW        = cnt_w(H_TOTAL);
   localparam int unsigned VW        = cnt_w(V_TOTAL);
   localparam int unsigned LXW       = cnt_w(TILE_W);
   localparam int unsigned LYW       = cnt_w(TILE_H);
   localparam int unsigned CW        = cnt_w(GRID_COLS + 1);
   localparam int unsigned RW        = cnt_w(GRID_ROWS + 1);
   localparam int unsigned NT        = GRID_COLS * GRID_ROWS;
   localparam int unsigned CA_W      = NT * CODE_W;
   localparam int unsigned SPRITE_SZ = TILE_W * TILE_H;
   localparam int unsigned L         = 3 + MEM_LAT;
   localparam sync_t       SYNC_RST  = '{hsync: (HSYNC_POL == 32'd0),
                                         vsync: (VSYNC_POL == 32'd0),
                                         de: 1'b0, fs: 1'b0};

   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic          hsync_c, vsync_c, de_c;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
      .V_ACTIVE (V_ACTIVE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK),
      .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL)
   ) u_timing (
      .clk_i    (CLK),
      .rst_ni   (RESET_N),
      .h_o      (h),
      .v_o      (v),
      .hsync_c_o(hsync_c),
      .vsync_c_o(vsync_c),
      .de_c_o   (de_c)
   );

   logic line_end_c, frame_end_c, frame_first_c;
   assign line_end_c    = (32'(h) == H_TOTAL - 32'd1);
   assign frame_end_c   = line_end_c && (32'(v) == V_TOTAL - 32'd1);
   assign frame_first_c = (h == '0) && (v == '0);

   logic [LXW-1:0]  lx_q, lx_d;
   logic [LYW-1:0]  ly_q, ly_d;
   logic [CW-1:0]   col_q, col_d;
   logic [RW-1:0]   row_q, row_d;
   logic [CA_W-1:0] codes_q, codes_d;

   // Tile position tracks the raster; column/row saturate once past the grid.
   always_comb begin
      lx_d  = lx_q + LXW'(1);
      ly_d  = ly_q;
      col_d = col_q;
      row_d = row_q;
      if (line_end_c) begin
         lx_d  = '0;
         col_d = '0;
         if (frame_end_c) begin
            ly_d  = '0;
            row_d = '0;
         end else if (32'(ly_q) == TILE_H - 32'd1) begin
            ly_d = '0;
            if (32'(row_q) < GRID_ROWS) row_d = row_q + RW'(1);
         end else begin
            ly_d = ly_q + LYW'(1);
         end
      end else if (32'(lx_q) == TILE_W - 32'd1) begin
         lx_d = '0;
         if (32'(col_q) < GRID_COLS) col_d = col_q + CW'(1);
      end
   end

   // The first pixel of a frame reads the live array so it sees the new codes.
   assign codes_d = frame_first_c ? CONTROL_ARRAY : codes_q;

   logic              in_grid_c;
   logic [CODE_W-1:0] code_c;

   always_comb begin
      in_grid_c = (32'(col_q) < GRID_COLS) && (32'(row_q) < GRID_ROWS);
      code_c    = '0;
      for (int unsigned k = 0; k < NT; k++) begin
         if (in_grid_c && (32'(row_q) * GRID_COLS + 32'(col_q) == k))
            code_c = codes_d[k*CODE_W +: CODE_W];
      end
   end

   logic [CODE_W-1:0]  code_s1_q;
   logic [LXW-1:0]     lx_s1_q;
   logic [LYW-1:0]     ly_s1_q;
   logic               area_s1_q;
   logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
   logic               en_s2_q, en_s2_d;
   logic [MEM_LAT-1:0] en_pipe_q, en_pipe_d;
   logic               pix_q, pix_d;
   sync_t              sync_c;
   sync_t [L-1:0]      sync_q, sync_d;

   assign rom_addr_d = ROM_AW'(32'(code_s1_q) * SPRITE_SZ + 32'(ly_s1_q) * TILE_W
                               + 32'(lx_s1_q));
   assign en_s2_d    = area_s1_q && (32'(code_s1_q) < NUM_SPRITES);
   assign pix_d      = en_pipe_q[MEM_LAT-1] & ROM_DATA;
   assign sync_c     = '{hsync: hsync_c, vsync: vsync_c, de: de_c, fs: frame_first_c};

   // Pixel-enable waits out the ROM latency; syncs ride the full pipeline depth.
   always_comb begin
      en_pipe_d    = '0;
      en_pipe_d[0] = en_s2_q;
      for (int unsigned i = 1; i < MEM_LAT; i++) en_pipe_d[i] = en_pipe_q[i-1];
      sync_d    = '0;
      sync_d[0] = sync_c;
      for (int unsigned i = 1; i < L; i++) sync_d[i] = sync_q[i-1];
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         lx_q       <= '0;
         ly_q       <= '0;
         col_q      <= '0;
         row_q      <= '0;
         codes_q    <= '0;
         code_s1_q  <= '0;
         lx_s1_q    <= '0;
         ly_s1_q    <= '0;
         area_s1_q  <= 1'b0;
         rom_addr_q <= '0;
         en_s2_q    <= 1'b0;
         en_pipe_q  <= '0;
         pix_q      <= 1'b0;
         sync_q     <= {L{SYNC_RST}};
      end else begin
         lx_q       <= lx_d;
         ly_q       <= ly_d;
         col_q      <= col_d;
         row_q      <= row_d;
         codes_q    <= codes_d;
         code_s1_q  <= code_c;
         lx_s1_q    <= lx_q;
         ly_s1_q    <= ly_q;
         area_s1_q  <= in_grid_c && de_c;
         rom_addr_q <= rom_addr_d;
         en_s2_q    <= en_s2_d;
         en_pipe_q  <= en_pipe_d;
         pix_q      <= pix_d;
         sync_q     <= sync_d;
      end
   end

   assign ROM_ADDR    = rom_addr_q;
   assign PIXEL_VALUE = pix_q;
   assign PIXEL_VALID = sync_q[L-1].de;
   assign HSYNC       = sync_q[L-1].hsync;
   assign VSYNC       = sync_q[L-1].vsync;
   assign FRAME_START = sync_q[L-1].fs;

endmodule

// File: doc/vga_grid_controller.md
VGA_GRID_CONTROLLER -- requirements
Module: vga_grid_controller

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT/H_SYNC/H_BACK, defaults 40/128/88, horizontal porch/sync widths in clocks.
REQ-003 SHALL have parameter V_ACTIVE, default 600, visible lines per frame.
REQ-004 SHALL have parameters V_FRONT/V_SYNC/V_BACK, defaults 1/4/23, vertical porch/sync widths in lines.
REQ-005 SHALL have parameters HSYNC_POL/VSYNC_POL, default 1/1, asserted sync level.
REQ-006 SHALL have parameters GRID_COLS/GRID_ROWS, default 3/3, tile grid size.
REQ-007 SHALL have parameters TILE_W/TILE_H, default 280/215, tile size in pixels.
REQ-008 SHALL have parameter CODE_W, default 4, tile code width; NUM_SPRITES, default 9, valid codes 0..NUM_SPRITES-1.
REQ-009 SHALL have parameter MEM_LAT, default 1, sprite ROM read latency in clocks (>=1).
REQ-010 Ports; one clock, synchronous active-low reset:
  CLK  in  1  clock
  RESET_N  in  1  synchronous active-low reset
  CONTROL_ARRAY  in  GRID_COLS*GRID_ROWS*CODE_W  tile codes, tile k=row*GRID_COLS+col at [k*CODE_W+:CODE_W]
  ROM_ADDR  out  $clog2(NUM_SPRITES*TILE_W*TILE_H)  registered sprite ROM address
  ROM_DATA  in  1  ROM pixel, valid MEM_LAT clocks after ROM_ADDR
  PIXEL_VALUE  out  1  pixel output
  PIXEL_VALID  out  1  active-area (display enable), aligned with PIXEL_VALUE
  HSYNC  out  1  line sync, aligned with PIXEL_VALUE
  VSYNC  out  1  frame sync, aligned with PIXEL_VALUE
  FRAME_START  out  1  one-clock pulse with first active pixel of frame

Function
REQ-011 H counter SHALL count 0..H_TOTAL-1 (H_TOTAL=sum of H params), wrap to 0; V counter SHALL increment on H wrap, count 0..V_TOTAL-1, wrap to 0.
REQ-012 CONTROL_ARRAY SHALL be latched only in the cycle H=0,V=0; mid-frame changes SHALL not affect the current frame.
REQ-013 Tile column/row and local x/y SHALL be tracked by incrementing counters (no divide/modulo): lx wraps at TILE_W advancing column; ly wraps at TILE_H advancing row; both reset at H=0 / V=0.
REQ-014 Pixel in tile area when H<H_ACTIVE, V<V_ACTIVE, col<GRID_COLS, row<GRID_ROWS; partial tiles clipped at active edge.
REQ-015 Stage 1 SHALL register tile code, lx, ly, in-area flag; stage 2 SHALL register ROM_ADDR=code*TILE_W*TILE_H+ly*TILE_W+lx, with code*TILE_W*TILE_H and ly*TILE_W formed by accumulation/constant multiply, width per REQ-010.
REQ-016 PIXEL_VALUE SHALL equal ROM_DATA when in-area and code<NUM_SPRITES, else 0; registered.
REQ-017 Total latency L=3+MEM_LAT clocks from counter value to PIXEL_VALUE; HSYNC, VSYNC, PIXEL_VALID, FRAME_START SHALL be delayed by the same L.
REQ-018 HSYNC asserted (=HSYNC_POL) for H in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1]; VSYNC asserted for V in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1], entire lines.
REQ-019 PIXEL_VALID high iff H<H_ACTIVE and V<V_ACTIVE (independent of grid coverage); PIXEL_VALUE SHALL be 0 whenever PIXEL_VALID low.
REQ-020 Out-of-grid active pixels SHALL output 0 with PIXEL_VALID high.

Reset
REQ-021 While RESET_N low at a clock edge: counters, tile counters, pipeline 0; latched codes 0; PIXEL_VALUE 0, PIXEL_VALID 0, FRAME_START 0, ROM_ADDR 0, HSYNC=!HSYNC_POL, VSYNC=!VSYNC_POL.
REQ-022 Reset asserted mid-frame SHALL flush pipeline; after release, counters start at H=0,V=0 and first FRAME_START occurs exactly L clocks later.

Structure
REQ-023 Default timing constants and $clog2-derived widths SHALL live in shared package vga_pkg.
REQ-024 Sync/counter generation SHALL be sub-module vga_timing_gen (outputs H, V, hsync, vsync, de); grid/tile pipeline stays in top.

Verification
REQ-025 Small params (H 16/2/4/2, V 8/1/2/1, grid 2x2, tile 6x3, MEM_LAT 2) -> HSYNC low-active pulse of 4 clocks per 24-clock line; VSYNC 2 lines per 12-line frame.
REQ-026 ROM model returning addr[0]; codes {0,1,2,3} -> PIXEL_VALUE matches addr parity, ROM_ADDR for tile 1, lx=2, ly=1 equals 18+6+2=26.
REQ-027 Change CONTROL_ARRAY at V=3 -> current frame unchanged; new codes appear from next frame.
REQ-028 Code 15 (>=NUM_SPRITES) in a tile -> that tile outputs 0 with PIXEL_VALID high.
REQ-029 RESET_N low at mid-line V=5 for 3 clocks -> outputs at reset values; FRAME_START pulses exactly L=5 clocks after release.
REQ-030 Defaults 800x600 -> out-of-grid column H>=840? none; H in 560..799 uses tile col 2, H=800 PIXEL_VALID low, verified over one full frame.
